// File: rtl/pm_gather.sv
// pm_gather: collects the four path metrics of one trellis step, normalizes
// them against their minimum and hands the vector to the ACS stage with a
// valid/ready handshake. Decision bits and best-state address ride along.
module pm_gather #(
  parameter int PM_W = 7,
  parameter int ID_W = 3,
  parameter int N_ST = 4
) (
  input  logic                   PM_clk,
  input  logic                   PM_rst,
  input  logic                   data_rdy,
  input  logic [1:0]             addr_in,
  input  logic [PM_W-1:0]        PM_in,
  input  logic                   dec_in,
  input  logic [ID_W-1:0]        data_id,
  input  logic                   acs_ready,
  output logic                   vec_valid,
  output logic [N_ST*PM_W-1:0]   pm_vec,
  output logic [N_ST-1:0]        dec_vec,
  output logic [1:0]             min_addr,
  output logic [ID_W-1:0]        id_out,
  output logic                   id_err,
  output logic                   dup_err,
  output logic                   ovf_err
);

  // Collect buffer
  logic [PM_W-1:0] buf_pm [N_ST];
  logic [N_ST-1:0] buf_dec;
  logic [ID_W-1:0] buf_id;
  logic [N_ST-1:0] mask;

  logic            full;
  logic            xfer;
  logic            drop;
  logic            accept;
  logic [N_ST-1:0] onehot;

  logic [PM_W-1:0]        min_pm;
  logic [1:0]             min_idx;
  logic [N_ST*PM_W-1:0]   norm_vec;

  assign full   = (mask == {N_ST{1'b1}});
  // Output register is free when empty or being drained this cycle.
  assign xfer   = full && (!vec_valid || acs_ready);
  // Buffer full and output still held: nowhere to put the beat.
  assign drop   = data_rdy && full && !xfer;
  assign accept = data_rdy && !drop;
  assign onehot = {{(N_ST-1){1'b0}}, 1'b1} << addr_in;

  // Minimum search (strict compare keeps the lowest index on ties) and normalization
  always_comb begin
    min_pm   = buf_pm[0];
    min_idx  = '0;
    norm_vec = '0;
    for (int s = 1; s < N_ST; s++) begin
      if (buf_pm[s] < min_pm) begin
        min_pm  = buf_pm[s];
        min_idx = 2'(s);
      end
    end
    for (int s = 0; s < N_ST; s++) begin
      norm_vec[s*PM_W +: PM_W] = buf_pm[s] - min_pm;
    end
  end

  // Collect buffer update and sticky error flags
  always_ff @(posedge PM_clk or negedge PM_rst) begin
    if (!PM_rst) begin
      for (int s = 0; s < N_ST; s++) buf_pm[s] <= '0;
      buf_dec <= '0;
      buf_id  <= '0;
      mask    <= '0;
      id_err  <= 1'b0;
      dup_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      if (xfer) mask <= '0;
      if (accept) begin
        buf_pm[addr_in]  <= PM_in;
        buf_dec[addr_in] <= dec_in;
        if (xfer || mask == '0) begin
          // Fresh collection (possibly into the buffer just emptied by a transfer)
          mask   <= onehot;
          buf_id <= data_id;
        end else if (data_id != buf_id) begin
          // Symbol changed before completion: abandon old beats, restart here
          id_err <= 1'b1;
          mask   <= onehot;
          buf_id <= data_id;
        end else begin
          if ((mask & onehot) != '0) dup_err <= 1'b1;
          mask <= mask | onehot;
        end
      end
      if (drop) ovf_err <= 1'b1;
    end
  end

  // Output register and handshake
  always_ff @(posedge PM_clk or negedge PM_rst) begin
    if (!PM_rst) begin
      vec_valid <= 1'b0;
      pm_vec    <= '0;
      dec_vec   <= '0;
      min_addr  <= '0;
      id_out    <= '0;
    end else if (xfer) begin
      vec_valid <= 1'b1;
      pm_vec    <= norm_vec;
      dec_vec   <= buf_dec;
      min_addr  <= min_idx;
      id_out    <= buf_id;
    end else if (acs_ready) begin
      vec_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pm_gather.sv
// Directed testbench for pm_gather with hand-computed expected vectors.
module tb_pm_gather;

  localparam int PM_W = 7;
  localparam int ID_W = 3;
  localparam int N_ST = 4;

  logic                 PM_clk = 1'b0;
  logic                 PM_rst;
  logic                 data_rdy;
  logic [1:0]           addr_in;
  logic [PM_W-1:0]      PM_in;
  logic                 dec_in;
  logic [ID_W-1:0]      data_id;
  logic                 acs_ready;
  logic                 vec_valid;
  logic [N_ST*PM_W-1:0] pm_vec;
  logic [N_ST-1:0]      dec_vec;
  logic [1:0]           min_addr;
  logic [ID_W-1:0]      id_out;
  logic                 id_err;
  logic                 dup_err;
  logic                 ovf_err;

  int nvec = 0;
  int nerr = 0;

  pm_gather #(.PM_W(PM_W), .ID_W(ID_W), .N_ST(N_ST)) dut (
    .PM_clk(PM_clk), .PM_rst(PM_rst), .data_rdy(data_rdy), .addr_in(addr_in),
    .PM_in(PM_in), .dec_in(dec_in), .data_id(data_id), .acs_ready(acs_ready),
    .vec_valid(vec_valid), .pm_vec(pm_vec), .dec_vec(dec_vec), .min_addr(min_addr),
    .id_out(id_out), .id_err(id_err), .dup_err(dup_err), .ovf_err(ovf_err)
  );

  always #5 PM_clk = ~PM_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_ST*PM_W-1:0] pk(input int a3, input int a2, input int a1, input int a0);
    pk = {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  // One input beat; returns 1 time unit after the sampling edge.
  task automatic beat(input logic [1:0] a, input int pm, input logic d, input logic [ID_W-1:0] id);
    data_rdy = 1'b1;
    addr_in  = a;
    PM_in    = 7'(pm);
    dec_in   = d;
    data_id  = id;
    @(posedge PM_clk);
    #1;
    data_rdy = 1'b0;
  endtask

  task automatic tick();
    @(posedge PM_clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [N_ST*PM_W-1:0] pv, input logic [3:0] dv,
                           input logic [1:0] ma, input logic [ID_W-1:0] id);
    check({tag, "_vv"},  64'(vec_valid), 64'(1));
    check({tag, "_pm"},  64'(pm_vec), 64'(pv));
    check({tag, "_dec"}, 64'(dec_vec), 64'(dv));
    check({tag, "_min"}, 64'(min_addr), 64'(ma));
    check({tag, "_id"},  64'(id_out), 64'(id));
  endtask

  initial begin
    PM_rst = 1'b0; data_rdy = 1'b0; addr_in = '0; PM_in = '0; dec_in = 1'b0;
    data_id = '0; acs_ready = 1'b0;
    #1;
    check("rst_vv",  64'(vec_valid), 64'(0));
    check("rst_pm",  64'(pm_vec), 64'(0));
    check("rst_err", 64'({id_err, dup_err, ovf_err}), 64'(0));
    tick(); tick();
    PM_rst = 1'b1;

    // Basic symbol: PM 20,15,40,15 -> min 15 at addr 1
    acs_ready = 1'b1;
    beat(2'd0, 20, 1'b1, 3'd3);
    beat(2'd1, 15, 1'b0, 3'd3);
    beat(2'd2, 40, 1'b1, 3'd3);
    beat(2'd3, 15, 1'b1, 3'd3);
    check("t1_lat", 64'(vec_valid), 64'(0));
    tick();
    check_vec("t1", pk(0, 25, 0, 5), 4'b1101, 2'd1, 3'd3);
    tick();
    check("t1_fall", 64'(vec_valid), 64'(0));

    // Out of order arrival, output held for 5 cycles
    acs_ready = 1'b0;
    beat(2'd2, 40, 1'b1, 3'd3);
    beat(2'd0, 20, 1'b1, 3'd3);
    beat(2'd3, 15, 1'b1, 3'd3);
    beat(2'd1, 15, 1'b0, 3'd3);
    tick();
    check_vec("t2", pk(0, 25, 0, 5), 4'b1101, 2'd1, 3'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_hold_vv", 64'(vec_valid), 64'(1));
      check("t2_hold_pm", 64'(pm_vec), 64'(pk(0, 25, 0, 5)));
    end
    acs_ready = 1'b1;
    tick();
    check("t2_fall", 64'(vec_valid), 64'(0));

    // Back-to-back symbols
    beat(2'd0, 10, 1'b0, 3'd1);
    beat(2'd1, 12, 1'b1, 3'd1);
    beat(2'd2, 11, 1'b0, 3'd1);
    beat(2'd3, 10, 1'b1, 3'd1);
    beat(2'd0, 100, 1'b1, 3'd2);
    check_vec("t3a", pk(0, 1, 2, 0), 4'b1010, 2'd0, 3'd1);
    beat(2'd1, 90, 1'b1, 3'd2);
    check("t3_gap", 64'(vec_valid), 64'(0));
    beat(2'd2, 95, 1'b1, 3'd2);
    beat(2'd3, 127, 1'b1, 3'd2);
    tick();
    check_vec("t3b", pk(37, 5, 0, 10), 4'b1111, 2'd1, 3'd2);
    check("t3_err", 64'({id_err, dup_err, ovf_err}), 64'(0));
    tick();

    // Id change mid-collection
    beat(2'd0, 5, 1'b1, 3'd4);
    beat(2'd1, 6, 1'b1, 3'd4);
    beat(2'd0, 30, 1'b0, 3'd5);
    check("t4_iderr", 64'(id_err), 64'(1));
    beat(2'd1, 20, 1'b0, 3'd5);
    beat(2'd2, 10, 1'b1, 3'd5);
    beat(2'd3, 40, 1'b0, 3'd5);
    check("t4_early", 64'(vec_valid), 64'(0));
    tick();
    check_vec("t4", pk(30, 0, 10, 20), 4'b0100, 2'd2, 3'd5);
    check("t4_dup", 64'(dup_err), 64'(0));
    tick();
    check("t4_single", 64'(vec_valid), 64'(0));

    // Overflow: output held, second symbol fills buffer, 9th beat dropped
    acs_ready = 1'b0;
    beat(2'd0, 1, 1'b0, 3'd6);
    beat(2'd1, 2, 1'b0, 3'd6);
    beat(2'd2, 3, 1'b0, 3'd6);
    beat(2'd3, 4, 1'b0, 3'd6);
    beat(2'd0, 50, 1'b1, 3'd7);
    check_vec("t5a", pk(3, 2, 1, 0), 4'b0000, 2'd0, 3'd6);
    beat(2'd1, 50, 1'b1, 3'd7);
    beat(2'd2, 60, 1'b0, 3'd7);
    beat(2'd3, 55, 1'b0, 3'd7);
    check("t5_noovf", 64'(ovf_err), 64'(0));
    beat(2'd2, 0, 1'b1, 3'd7);
    check("t5_ovf", 64'(ovf_err), 64'(1));
    check("t5_dup", 64'(dup_err), 64'(0));
    check_vec("t5a_held", pk(3, 2, 1, 0), 4'b0000, 2'd0, 3'd6);
    acs_ready = 1'b1;
    tick();
    check_vec("t5b", pk(5, 10, 0, 0), 4'b0011, 2'd0, 3'd7);
    tick();
    check("t5_fall", 64'(vec_valid), 64'(0));

    // Asynchronous reset with output valid and a partial collection
    acs_ready = 1'b0;
    beat(2'd0, 20, 1'b1, 3'd1);
    beat(2'd1, 15, 1'b0, 3'd1);
    beat(2'd2, 40, 1'b1, 3'd1);
    beat(2'd3, 15, 1'b1, 3'd1);
    tick();
    check("t6_vv", 64'(vec_valid), 64'(1));
    beat(2'd0, 9, 1'b0, 3'd2);
    beat(2'd1, 9, 1'b0, 3'd2);
    #2;
    PM_rst = 1'b0;
    #1;
    check("t6_async_vv", 64'(vec_valid), 64'(0));
    check("t6_async_out", 64'({pm_vec, dec_vec, min_addr, id_out}), 64'(0));
    check("t6_async_err", 64'({id_err, dup_err, ovf_err}), 64'(0));
    tick();
    PM_rst = 1'b1;
    acs_ready = 1'b1;
    beat(2'd0, 20, 1'b1, 3'd2);
    beat(2'd1, 15, 1'b0, 3'd2);
    beat(2'd2, 40, 1'b1, 3'd2);
    beat(2'd3, 15, 1'b1, 3'd2);
    tick();
    check_vec("t6", pk(0, 25, 0, 5), 4'b1101, 2'd1, 3'd2);
    check("t6_err", 64'({id_err, dup_err, ovf_err}), 64'(0));
    tick();

    // Duplicate address overwrites the entry
    beat(2'd0, 9, 1'b1, 3'd3);
    beat(2'd0, 3, 1'b0, 3'd3);
    check("t7_dup", 64'(dup_err), 64'(1));
    beat(2'd1, 4, 1'b1, 3'd3);
    beat(2'd2, 5, 1'b0, 3'd3);
    beat(2'd3, 6, 1'b1, 3'd3);
    tick();
    check_vec("t7", pk(3, 2, 1, 0), 4'b1010, 2'd0, 3'd3);
    check("t7_iderr", 64'(id_err), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
